// File: rtl/scan_sequencer_4b.sv
// Index sequencer producing the registered select/enable pair for a 4-to-16 decoder.
// Walks first..last (mod 16) with a programmable dwell and an optional blank cycle.
module scan_sequencer_4b #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [3:0]         first,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam int unsigned IDX_W = 4;
  localparam bit          USE_GAP = (BLANK != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic               cont;
    logic [IDX_W-1:0]   first;
    logic [IDX_W-1:0]   last;
    logic [DWELL_W-1:0] dwell;
  } cfg_t;

  state_t             state, state_nxt;
  cfg_t               cfg, cfg_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]   sel_nxt;
  logic               sel_en_nxt, busy_nxt, done_nxt, wrap_nxt;

  // State, latched configuration, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cfg    <= '0;
      cnt    <= '0;
      sel    <= '0;
      sel_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cfg    <= cfg_nxt;
      cnt    <= cnt_nxt;
      sel    <= sel_nxt;
      sel_en <= sel_en_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      wrap   <= wrap_nxt;
    end
  end

  // Next-state and next-output logic; stop always wins over completion and wrap.
  always_comb begin
    state_nxt  = state;
    cfg_nxt    = cfg;
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    sel_en_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    wrap_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          cfg_nxt.cont  = cont;
          cfg_nxt.first = first;
          cfg_nxt.last  = last;
          cfg_nxt.dwell = dwell;
          sel_nxt       = first;
          cnt_nxt       = dwell;
          state_nxt     = SCAN;
          sel_en_nxt    = 1'b1;
          busy_nxt      = 1'b1;
        end
      end

      SCAN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt    = cnt - DWELL_W'(1);
          sel_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end else if (sel != cfg.last) begin
          sel_nxt    = IDX_W'(sel + IDX_W'(1));
          cnt_nxt    = cfg.dwell;
          busy_nxt   = 1'b1;
          state_nxt  = USE_GAP ? GAP : SCAN;
          sel_en_nxt = !USE_GAP;
        end else if (!cfg.cont) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          sel_nxt    = cfg.first;
          cnt_nxt    = cfg.dwell;
          wrap_nxt   = 1'b1;
          busy_nxt   = 1'b1;
          state_nxt  = USE_GAP ? GAP : SCAN;
          sel_en_nxt = !USE_GAP;
        end
      end

      GAP: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = SCAN;
          sel_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer_4b.sv
// Directed bench for scan_sequencer_4b: vector table plus hand-written multi-cycle sequences.
module tb_scan_sequencer_4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, cont;
  logic [3:0] first, last;
  logic [7:0] dwell;
  logic [3:0] sel;
  logic       sel_en, busy, done, wrap;

  int checks = 0;
  int errors = 0;

  scan_sequencer_4b #(.DWELL_W(8), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .first(first), .last(last), .dwell(dwell),
    .sel(sel), .sel_en(sel_en), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, ct;
    logic [3:0] fi, la;
    logic [7:0] dw;
    logic [3:0] e_sel;
    logic       e_en, e_busy, e_done, e_wrap;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic sp, logic ct, logic [3:0] fi, logic [3:0] la,
                              logic [7:0] dw, logic [3:0] es, logic ee, logic eb,
                              logic ed, logic ew);
    vec_t v;
    v.st = st; v.sp = sp; v.ct = ct; v.fi = fi; v.la = la; v.dw = dw;
    v.e_sel = es; v.e_en = ee; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
    return v;
  endfunction

  // Compares {sel, sel_en, busy, done, wrap} against the expected tuple.
  task automatic chk(input string name, input logic [3:0] es, input logic ee, input logic eb,
                     input logic ed, input logic ew);
    logic [7:0] act, exp;
    act = {sel, sel_en, busy, done, wrap};
    exp = {es, ee, eb, ed, ew};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sel=%0d en=%b busy=%b done=%b wrap=%b, expected sel=%0d en=%b busy=%b done=%b wrap=%b",
               name, act[7:4], act[3], act[2], act[1], act[0], es, ee, eb, ed, ew);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic ct, input logic [3:0] fi,
                       input logic [3:0] la, input logic [7:0] dw);
    start = st; stop = sp; cont = ct; first = fi; last = la; dwell = dw;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 4'd0, 4'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'd0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // single pass 0..3, dwell 0
    vq.push_back(mk(1,0,0, 0, 3,0,  0,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  1,0,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  1,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  2,0,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  2,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  3,0,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  3,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  3,0,0,1,0));
    vq.push_back(mk(0,0,0, 0, 3,0,  3,0,0,0,0));
    // continuous 5..6, dwell 1, then stop
    vq.push_back(mk(1,0,1, 5, 6,1,  5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  6,0,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  6,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  6,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  5,0,1,0,1));
    vq.push_back(mk(0,0,0, 0, 0,0,  5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  6,0,1,0,0));
    vq.push_back(mk(0,1,0, 0, 0,0,  6,0,0,0,0));
    vq.push_back(mk(0,0,0, 0, 0,0,  6,0,0,0,0));
    vq.push_back(mk(1,1,0, 2, 3,0,  6,0,0,0,0));
    // stop on final hold cycle of last
    vq.push_back(mk(1,0,0, 2, 3,0,  2,1,1,0,0));
    vq.push_back(mk(0,0,0, 2, 3,0,  3,0,1,0,0));
    vq.push_back(mk(0,0,0, 2, 3,0,  3,1,1,0,0));
    vq.push_back(mk(0,1,0, 2, 3,0,  3,0,0,0,0));
    vq.push_back(mk(0,0,0, 2, 3,0,  3,0,0,0,0));
    // start mid-scan ignored, then restart in the done cycle
    vq.push_back(mk(1,0,0, 0, 1,1,  0,1,1,0,0));
    vq.push_back(mk(1,0,1, 7, 9,5,  0,1,1,0,0));
    vq.push_back(mk(0,0,0, 7, 9,5,  1,0,1,0,0));
    vq.push_back(mk(0,0,0, 7, 9,5,  1,1,1,0,0));
    vq.push_back(mk(0,0,0, 7, 9,5,  1,1,1,0,0));
    vq.push_back(mk(0,0,0, 7, 9,5,  1,0,0,1,0));
    vq.push_back(mk(1,0,0, 4, 4,0,  4,1,1,0,0));
    vq.push_back(mk(0,0,0, 4, 4,0,  4,0,0,1,0));
    vq.push_back(mk(0,0,0, 4, 4,0,  4,0,0,0,0));

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].sp, vq[i].ct, vq[i].fi, vq[i].la, vq[i].dw);
      step();
      chk($sformatf("vec%0d", i), vq[i].e_sel, vq[i].e_en, vq[i].e_busy, vq[i].e_done, vq[i].e_wrap);
    end
    drive(0, 0, 0, 4'd0, 4'd0, 8'd0);

    // wrap-around range 14..1 with dwell 2: 4 indices * 3 + 3 gaps = 15 cycles
    drive(1, 0, 0, 4'd14, 4'd1, 8'd2);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] idx;
      idx = 4'(14 + k);
      for (int h = 0; h < 3; h++) begin
        step();
        drive(0, 0, 1, 4'd3, 4'd3, 8'd0);
        chk($sformatf("wrap_rng_hold%0d_%0d", k, h), idx, 1, 1, 0, 0);
      end
      if (k < 3) begin
        step();
        chk($sformatf("wrap_rng_gap%0d", k), 4'(idx + 4'd1), 0, 1, 0, 0);
      end
    end
    step();
    chk("wrap_rng_done", 4'd1, 0, 0, 1, 0);
    step();
    chk("wrap_rng_idle", 4'd1, 0, 0, 0, 0);

    // asynchronous reset between edges while scanning
    drive(1, 0, 1, 4'd7, 4'd8, 8'd3);
    step();
    drive(0, 0, 0, 4'd0, 4'd0, 8'd0);
    step();
    chk("pre_reset_scan", 4'd7, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 4'd0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_reset_idle", 4'd0, 0, 0, 0, 0);

    // first==last with maximum dwell: 256 enabled cycles then done
    drive(1, 0, 0, 4'd9, 4'd9, 8'd255);
    begin
      int held;
      held = 0;
      for (int c = 0; c < 300; c++) begin
        step();
        drive(0, 0, 0, 4'd0, 4'd0, 8'd0);
        if (!(sel_en && sel == 4'd9)) break;
        held++;
      end
      checks++;
      if (held != 256) begin
        errors++;
        $display("FAIL long_dwell_len: got %0d enabled cycles, expected 256", held);
      end
      chk("long_dwell_done", 4'd9, 0, 0, 1, 0);
    end
    step();
    chk("long_dwell_idle", 4'd9, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
